spi_slave_rx_tx: RTL and testbench

Mode-0 SPI responder that faces an external SPI master. It oversamples the master's `sclk`, `cs_n` and `mosi` in the local `clk` domain and deserialises MSB-first words into `rx_data` with a one-cycle `rx_valid` strobe. In the same frame it serialises a word loaded by local logic onto `miso`. It pairs with the on-chip clock divider and SPI master as the opposite end of the link.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 33 +++
 rtl/spi_slave_rx_tx.sv | 136 +++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI link definitions: word width, responder FSM states and the
// clock mode used by both ends of the link.
`timescale 1ns/1ps
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // Mode 0: sclk idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin plus rise/fall detection.
// Edges are flagged combinationally in the cycle the synchronised value changes.
`timescale 1ns/1ps
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 SPI responder: oversamples sclk/cs_n/mosi, deserialises MSB-first words
// and serialises a single-entry holding register onto miso (edge-to-effect SYNC_STAGES+1 clk).
`timescale 1ns/1ps
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [0:0]             state;
  logic [CW-1:0]          bit_cnt;
  logic [WIDTH-1:0]       rx_shift;
  logic [WIDTH-1:0]       tx_shift;
  logic [WIDTH-1:0]       hold;
  logic                   tx_pending;
  logic                   reload;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_sync;

  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic load_ok, consume;
  logic [WIDTH-1:0] slot_word;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sclk_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  // mosi needs only its level; sclk edges already align it with the capture point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_chain <= '0;
    else     mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_sync = mosi_chain[SYNC_STAGES-1];

  // A slot consumes the holding word at frame start and after each completed word.
  assign consume   = ((state == ST_IDLE) && cs_fall) ||
                     ((state == ST_ACTIVE) && !cs_rise && sclk_fall && reload);
  assign slot_word = tx_pending ? hold : '0;
  assign load_ok   = tx_load && !tx_pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold       <= '0;
      tx_pending <= 1'b0;
    end else begin
      if (load_ok) hold <= tx_data;
      tx_pending <= (tx_pending && !consume) || load_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      reload   <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_ACTIVE;
            tx_shift <= slot_word;
            bit_cnt  <= '0;
            rx_shift <= '0;
            reload   <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            rx_shift <= '0;
            tx_shift <= '0;
            reload   <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync};
            if (bit_cnt == CW'(WIDTH - 1)) begin
              rx_data  <= {rx_shift[WIDTH-2:0], mosi_sync};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              reload   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload) begin
              tx_shift <= slot_word;
              reload   <= 1'b0;
            end else begin
              tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign miso     = tx_shift[WIDTH-1];
  assign tx_ready = !tx_pending;
  assign busy     = (state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: a pin-level SPI master with randomized data and phase
// lengths, checked against a transaction-level model of the holding register and link.
`timescale 1ns/1ps
module tb_spi_slave_rx_tx;
  import spi_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sclk = 1'b0;
  logic         cs_n = 1'b1;
  logic         mosi = 1'b0;
  logic         miso;
  logic [W-1:0] tx_data = '0;
  logic         tx_load = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;

  spi_slave_rx_tx #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .tx_data  (tx_data),
    .tx_load  (tx_load),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_pulse = 0;

  // Model: one-entry holding register, last received word, expected rx words.
  logic         m_pending = 1'b0;
  logic [W-1:0] m_hold = '0;
  logic [W-1:0] m_rx = '0;
  logic [W-1:0] exp_rx[$];
  // busy is the pin-level cs_n seen through SYNC_STAGES+1 clock edges.
  logic [2:0]   cs_pipe = 3'b111;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] take_slot();
    take_slot = m_pending ? m_hold : '0;
    m_pending = 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) cs_pipe <= 3'b111;
    else     cs_pipe <= {cs_pipe[1:0], cs_n};
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        n_pulse++;
        if (exp_rx.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rx_valid: pulse with data %0h but no word expected at %0t", rx_data, $time);
        end else begin
          m_rx = exp_rx.pop_front();
          check("rx_data_word", 32'(rx_data), 32'(m_rx));
        end
      end
      check("rx_data_hold", 32'(rx_data), 32'(m_rx));
      check("busy", 32'(busy), 32'(!cs_pipe[2]));
      if (!busy) check("miso_idle", 32'(miso), 32'(0));
    end
  end

  task automatic load(input logic [W-1:0] d);
    check("tx_ready_at_load", 32'(tx_ready), 32'(!m_pending));
    tx_data = d;
    tx_load = 1'b1;
    @(negedge clk);
    tx_load = 1'b0;
    if (!m_pending) begin
      m_pending = 1'b1;
      m_hold    = d;
    end
  endtask

  task automatic half_phase();
    repeat ($urandom_range(4, 6)) @(negedge clk);
  endtask

  task automatic xfer(input logic [23:0] mo, input int nbits, input bit mid_load,
                      input logic [W-1:0] mid_val, output logic [23:0] mi);
    logic [W-1:0] slot;
    logic [W-1:0] got;
    got  = '0;
    mi   = '0;
    cs_n = 1'b0;
    mosi = mo[nbits-1];
    slot = take_slot();
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[nbits-1-i];
      half_phase();
      sclk = 1'b1;
      mi   = {mi[22:0], miso};
      got  = {got[W-2:0], miso};
      if (i % W == W - 1) exp_rx.push_back(mo[nbits-1-i +: W]);
      if (mid_load && i == 2) begin
        @(negedge clk);
        load(mid_val);
      end
      half_phase();
      sclk = 1'b0;
      if (i % W == W - 1) begin
        check("miso_word", 32'(got), 32'(slot));
        slot = take_slot();
      end
    end
    half_phase();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    check("tx_ready_after_frame", 32'(tx_ready), 32'(!m_pending));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [23:0] mi;
    int          p0;
    repeat (3) @(negedge clk);
    check("reset_miso", 32'(miso), 32'(0));
    check("reset_tx_ready", 32'(tx_ready), 32'(1));
    check("reset_rx_data", 32'(rx_data), 32'(0));
    check("reset_rx_valid", 32'(rx_valid), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single word
    p0 = n_pulse;
    load(8'hA5);
    xfer(24'h3C, 8, 1'b0, 8'h00, mi);
    check("single_miso", 32'(mi[7:0]), 32'(8'hA5));
    check("single_rx", 32'(rx_data), 32'(8'h3C));
    check("single_pulses", 32'(n_pulse - p0), 32'(1));

    // Back-to-back words, second loaded mid-frame
    p0 = n_pulse;
    load(8'hA5);
    xfer(24'h1122, 16, 1'b1, 8'h5A, mi);
    check("b2b_miso", 32'(mi[15:0]), 32'(16'hA55A));
    check("b2b_rx", 32'(rx_data), 32'(8'h22));
    check("b2b_pulses", 32'(n_pulse - p0), 32'(2));

    // Nothing pending
    xfer(24'hFF, 8, 1'b0, 8'h00, mi);
    check("noload_miso", 32'(mi[7:0]), 32'(8'h00));
    check("noload_rx", 32'(rx_data), 32'(8'hFF));

    // Abort after 5 bits
    p0 = n_pulse;
    load(8'hC3);
    xfer(24'h15, 5, 1'b0, 8'h00, mi);
    check("abort_miso_bits", 32'(mi[4:0]), 32'(5'b11000));
    check("abort_pulses", 32'(n_pulse - p0), 32'(0));
    check("abort_rx_kept", 32'(rx_data), 32'(8'hFF));
    xfer(24'h81, 8, 1'b0, 8'h00, mi);
    check("after_abort_miso", 32'(mi[7:0]), 32'(8'h00));
    load(8'h96);
    xfer(24'h42, 8, 1'b0, 8'h00, mi);
    check("reload_miso", 32'(mi[7:0]), 32'(8'h96));

    // Load while holding register is full is ignored
    load(8'hA5);
    load(8'h77);
    xfer(24'h5C, 8, 1'b0, 8'h00, mi);
    check("ignored_load_miso", 32'(mi[7:0]), 32'(8'hA5));

    // Reset in the middle of a frame
    load(8'hFF);
    cs_n = 1'b0;
    mosi = 1'b1;
    void'(take_slot());
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    check("pre_reset_miso", 32'(miso), 32'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_miso", 32'(miso), 32'(0));
    check("midrst_tx_ready", 32'(tx_ready), 32'(1));
    check("midrst_rx_data", 32'(rx_data), 32'(0));
    check("midrst_rx_valid", 32'(rx_valid), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    m_pending = 1'b0;
    m_rx      = '0;
    exp_rx.delete();
    sclk = 1'b0;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    load(8'h5A);
    xfer(24'hE1, 8, 1'b0, 8'h00, mi);
    check("post_reset_miso", 32'(mi[7:0]), 32'(8'h5A));
    check("post_reset_rx", 32'(rx_data), 32'(8'hE1));

    // Randomized frames: 1-3 words, optional abort, optional loads
    for (int k = 0; k < 40; k++) begin
      int          nw;
      int          nbits;
      bit          mid;
      logic [23:0] mo;
      nw    = $urandom_range(1, 3);
      nbits = nw * W;
      if ($urandom_range(0, 4) == 0) nbits = nbits - $urandom_range(1, 7);
      mo    = 24'($urandom);
      if ($urandom_range(0, 1) == 1) load(8'($urandom));
      mid   = (nbits >= 3) && ($urandom_range(0, 1) == 1);
      xfer(mo, nbits, mid, 8'($urandom), mi);
    end

    repeat (10) @(negedge clk);
    check("rx_words_outstanding", 32'(exp_rx.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
